// File: rtl/axi_b_resp_scheduler.sv
// AXI write-response scheduler: round-robin merge of slave-side B streams plus a
// locally queued DECERR source onto one registered master-side B channel.
module axi_b_resp_scheduler #(
  parameter int N_INIT_PORT    = 4,
  parameter int AXI_ID_IN      = 16,
  parameter int AXI_ID_OUT     = 18,
  parameter int AXI_USER_W     = 6,
  parameter int ERR_FIFO_DEPTH = 4,
  parameter int CNT_W          = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
  input  logic [N_INIT_PORT*2-1:0]          bresp_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
  input  logic [N_INIT_PORT-1:0]            bvalid_i,
  output logic [N_INIT_PORT-1:0]            bready_o,
  output logic [AXI_ID_IN-1:0]              bid_o,
  output logic [1:0]                        bresp_o,
  output logic [AXI_USER_W-1:0]             buser_o,
  output logic                              bvalid_o,
  input  logic                              bready_i,
  input  logic                              incr_req_i,
  input  logic                              err_push_i,
  input  logic [AXI_ID_IN-1:0]              err_id_i,
  input  logic [AXI_USER_W-1:0]             err_user_i,
  output logic                              err_full_o,
  output logic                              full_counter_o,
  output logic                              outstanding_trans_o
);

  localparam int N_REQ = N_INIT_PORT + 1;
  localparam int RR_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(ERR_FIFO_DEPTH);

  logic [RR_W-1:0]       rr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [AXI_ID_IN-1:0]  err_id_mem   [ERR_FIFO_DEPTH];
  logic [AXI_USER_W-1:0] err_user_mem [ERR_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        err_cnt;

  logic [N_REQ-1:0]      req;
  logic [RR_W-1:0]       winner;
  logic                  found;
  logic                  load, err_win, slave_load, push, pop;
  logic [AXI_ID_IN-1:0]  sel_id;
  logic [1:0]            sel_resp;
  logic [AXI_USER_W-1:0] sel_user;
  logic                  unused_id_bits;

  // DECERR waits until every routed write has had its response loaded
  assign req = {(err_cnt != '0) && (cnt_q == '0), bvalid_i};

  always_comb begin
    int idx;
    logic [RR_W-1:0] idx_r;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_r  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_r = RR_W'(idx);
      if (!found && req[idx_r]) begin
        found  = 1'b1;
        winner = idx_r;
      end
    end
  end

  assign err_win    = (winner == RR_W'(N_INIT_PORT));
  assign load       = rst_n && (!bvalid_o || bready_i) && found;
  assign slave_load = load && !err_win;
  assign pop        = load && err_win;
  assign push       = err_push_i && !err_full_o;

  always_comb begin
    bready_o = '0;
    sel_id   = err_id_mem[rd_ptr];
    sel_resp = 2'b11;
    sel_user = err_user_mem[rd_ptr];
    for (int k = 0; k < N_INIT_PORT; k++) begin
      bready_o[k] = load && (winner == RR_W'(k));
      if (winner == RR_W'(k)) begin
        sel_id   = bid_i[k*AXI_ID_OUT +: AXI_ID_IN];
        sel_resp = bresp_i[k*2 +: 2];
        sel_user = buser_i[k*AXI_USER_W +: AXI_USER_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_o <= 1'b0;
      bid_o    <= '0;
      bresp_o  <= '0;
      buser_o  <= '0;
      rr_q     <= '0;
    end else if (load) begin
      bvalid_o <= 1'b1;
      bid_o    <= sel_id;
      bresp_o  <= sel_resp;
      buser_o  <= sel_user;
      rr_q     <= err_win ? '0 : winner + RR_W'(1);
    end else if (bready_i) begin
      bvalid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (incr_req_i && !slave_load && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (slave_load && !incr_req_i && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      err_id_mem[wr_ptr]   <= err_id_i;
      err_user_mem[wr_ptr] <= err_user_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      err_cnt <= err_cnt + (PTR_W+1)'(1);
      else if (pop && !push) err_cnt <= err_cnt - (PTR_W+1)'(1);
    end
  end

  assign err_full_o          = (err_cnt == (PTR_W+1)'(ERR_FIFO_DEPTH));
  assign full_counter_o      = &cnt_q;
  assign outstanding_trans_o = |cnt_q;

  // upper slave-side ID bits are routing bits and are stripped here
  assign unused_id_bits = ^bid_i;

endmodule

// File: tb/tb_axi_b_resp_scheduler.sv
// Scoreboard bench for axi_b_resp_scheduler: per-port source queues drive the
// slave side, expected master-side beats are queued in grant order and popped on handshake.
module tb_axi_b_resp_scheduler;
  localparam int NP = 4, IDI = 16, IDO = 18, UW = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*IDO-1:0] bid_i = '0;
  logic [NP*2-1:0]   bresp_i = '0;
  logic [NP*UW-1:0]  buser_i = '0;
  logic [NP-1:0]     bvalid_i = '0;
  logic [NP-1:0]     bready_o;
  logic [IDI-1:0]    bid_o;
  logic [1:0]        bresp_o;
  logic [UW-1:0]     buser_o;
  logic              bvalid_o;
  logic              bready_i = 1'b1;
  logic              incr_req_i = 1'b0;
  logic              err_push_i = 1'b0;
  logic [IDI-1:0]    err_id_i = '0;
  logic [UW-1:0]     err_user_i = '0;
  logic              err_full_o, full_counter_o, outstanding_trans_o;

  axi_b_resp_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o), .bvalid_o(bvalid_o),
    .bready_i(bready_i),
    .incr_req_i(incr_req_i), .err_push_i(err_push_i),
    .err_id_i(err_id_i), .err_user_i(err_user_i), .err_full_o(err_full_o),
    .full_counter_o(full_counter_o), .outstanding_trans_o(outstanding_trans_o)
  );

  always #5 clk = ~clk;

  logic [IDO+2+UW-1:0] pq [NP][$];
  logic [IDI+2+UW-1:0] exp_q [$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [IDO+2+UW-1:0] b;
    for (int k = 0; k < NP; k++) begin
      if (pq[k].size() != 0) begin
        b = pq[k][0];
        bid_i[k*IDO +: IDO]  = b[IDO+2+UW-1 -: IDO];
        bresp_i[k*2 +: 2]    = b[UW+1 -: 2];
        buser_i[k*UW +: UW]  = b[UW-1:0];
        bvalid_i[k]          = 1'b1;
      end else begin
        bvalid_i[k] = 1'b0;
      end
    end
  endtask

  // one clock: sample handshakes mid-cycle, then re-drive sources after the edge
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NP; k++)
      if (bvalid_i[k] && bready_o[k]) void'(pq[k].pop_front());
    if (bvalid_o && bready_i) begin
      if (exp_q.size() == 0) chk("b_unexpected", 32'(exp_q.size()), 1);
      else chk("b_beat", {bid_o, bresp_o, buser_o}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic beat(input int k, input logic [IDO-1:0] id, input logic [1:0] resp,
                      input logic [UW-1:0] user, input bit expect_it);
    pq[k].push_back({id, resp, user});
    if (expect_it) exp_q.push_back({id[IDI-1:0], resp, user});
    drive();
  endtask

  task automatic expect_err(input logic [IDI-1:0] id, input logic [UW-1:0] user);
    exp_q.push_back({id, 2'b11, user});
  endtask

  task automatic push_err(input logic [IDI-1:0] id, input logic [UW-1:0] user);
    err_push_i = 1'b1;
    err_id_i   = id;
    err_user_i = user;
    step();
    err_push_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int max, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  int n;

  initial begin
    // T1: reset with all ports requesting, then release
    for (int k = 0; k < NP; k++)
      beat(k, {2'(k), 16'h1000 + 16'(k)}, 2'(k), 6'(k + 1), 1'b1);
    step();
    step();
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_bid", bid_o, 0);
    chk("rst_bresp", bresp_o, 0);
    chk("rst_buser", buser_o, 0);
    chk("rst_err_full", err_full_o, 0);
    chk("rst_full_cnt", full_counter_o, 0);
    chk("rst_outstanding", outstanding_trans_o, 0);
    rst_n = 1'b1;
    drain("t1_drain", 20, n);
    chk("t1_cycles", n, 5);

    // T2: backpressure on a held response
    bready_i = 1'b0;
    beat(2, 18'h2_00A5, 2'b01, 6'h15, 1'b1);
    beat(3, 18'h1_3333, 2'b10, 6'h33, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", bvalid_o, 1);
      chk("t2_hold_id", bid_o, 16'h00A5);
      chk("t2_bready", bready_o, 0);
    end
    bready_i = 1'b1;
    drain("t2_drain", 10, n);

    // T3: DECERR must not overtake outstanding slave responses
    incr_req_i = 1'b1;
    repeat (3) step();
    incr_req_i = 1'b0;
    chk("t3_outstanding", outstanding_trans_o, 1);
    push_err(16'h0042, 6'h2A);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_no_early_err", bvalid_o, 0);
    end
    beat(0, 18'h0_0A00, 2'b00, 6'h01, 1'b1);
    beat(1, 18'h0_0A01, 2'b01, 6'h02, 1'b1);
    beat(2, 18'h0_0A02, 2'b10, 6'h03, 1'b1);
    expect_err(16'h0042, 6'h2A);
    chk("t3_err_full", err_full_o, 0);
    drain("t3_drain", 20, n);
    chk("t3_err_full_end", err_full_o, 0);
    chk("t3_outstanding_end", outstanding_trans_o, 0);

    // T4: fill the DECERR queue behind a stalled output
    bready_i = 1'b0;
    beat(1, 18'h3_0B01, 2'b00, 6'h0B, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      push_err(16'h0100 + 16'(i), 6'(i + 8));
      if (i < 4) expect_err(16'h0100 + 16'(i), 6'(i + 8));
      if (i == 2) chk("t4_not_full", err_full_o, 0);
      if (i >= 3) chk("t4_full", err_full_o, 1);
    end
    bready_i = 1'b1;
    drain("t4_drain", 20, n);
    repeat (3) step();
    chk("t4_err_full_end", err_full_o, 0);

    // T5: outstanding counter saturation and reset mid-operation
    incr_req_i = 1'b1;
    repeat (1022) step();
    chk("t5_below_full", full_counter_o, 0);
    step();
    chk("t5_full", full_counter_o, 1);
    step();
    chk("t5_sat_hold", full_counter_o, 1);
    chk("t5_sat_outst", outstanding_trans_o, 1);
    beat(1, 18'h0_0C01, 2'b01, 6'h0C, 1'b1);
    step();
    incr_req_i = 1'b0;
    chk("t5_incr_decr", full_counter_o, 1);
    beat(2, 18'h0_0C02, 2'b10, 6'h0D, 1'b1);
    step();
    chk("t5_decr_full", full_counter_o, 0);
    chk("t5_decr_outst", outstanding_trans_o, 1);
    drain("t5_drain", 10, n);
    bready_i = 1'b0;
    beat(0, 18'h0_0DDD, 2'b00, 6'h1D, 1'b0);
    step();
    for (int i = 0; i < 4; i++) push_err(16'h0E00 + 16'(i), 6'h0E);
    chk("t5_q_full", err_full_o, 1);
    rst_n = 1'b0;
    for (int k = 0; k < NP; k++) pq[k].delete();
    drive();
    #1;
    chk("t5_rst_bvalid", bvalid_o, 0);
    chk("t5_rst_err_full", err_full_o, 0);
    chk("t5_rst_outst", outstanding_trans_o, 0);
    step();
    rst_n = 1'b1;
    bready_i = 1'b1;
    repeat (4) step();
    beat(3, 18'h0_0F03, 2'b11, 6'h0F, 1'b1);
    step();
    chk("t5_decr0_outst", outstanding_trans_o, 0);
    chk("t5_decr0_full", full_counter_o, 0);
    drain("t5_drain2", 10, n);

    // T6: fairness across all ports and the error source
    push_err(16'h0077, 6'h07);
    expect_err(16'h0077, 6'h07);
    drain("t6_pre_drain", 10, n);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NP; k++)
        beat(k, {2'(r), 16'h6000 + 16'(r*16 + k)}, 2'(k), 6'(r*8 + k), 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NP; k++)
        exp_q.push_back({16'h6000 + 16'(r*16 + k), 2'(k), 6'(r*8 + k)});
      expect_err(16'h0600 + 16'(r), 6'(r + 40));
    end
    push_err(16'h0600, 6'd40);
    push_err(16'h0601, 6'd41);
    drain("t6_drain", 30, n);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
